// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the pipe_* pipeline stages.
// State encoding and datapath widths used by the MEM stage.
package pipe_mem_pkg;

    localparam int WORD_W = 32;
    localparam int REGN_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Synchronous clear, bubble insertion and load-data capture.
module mem_wb_reg
    import pipe_mem_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              bubble,
    input  logic              en,
    input  logic              cap,
    input  logic              next_wreg,
    input  logic              next_m2reg,
    input  logic [REGN_W-1:0] next_wn,
    input  logic [WORD_W-1:0] next_alu,
    input  logic [WORD_W-1:0] next_mem,
    output logic              wb_wreg,
    output logic              wb_m2reg,
    output logic [REGN_W-1:0] wb_wn,
    output logic [WORD_W-1:0] wb_alu,
    output logic [WORD_W-1:0] wb_mem
);

    // Clear beats bubble; a bubble only kills the write enables.
    always_ff @(posedge clk) begin
        if (clr) begin
            wb_wreg  <= 1'b0;
            wb_m2reg <= 1'b0;
            wb_wn    <= '0;
            wb_alu   <= '0;
            wb_mem   <= '0;
        end else if (bubble) begin
            wb_wreg  <= 1'b0;
            wb_m2reg <= 1'b0;
        end else if (en) begin
            wb_wreg  <= next_wreg;
            wb_m2reg <= next_m2reg;
            wb_wn    <= next_wn;
            wb_alu   <= next_alu;
            if (cap) begin
                wb_mem <= next_mem;
            end
        end
    end

endmodule

// File: rtl/pipe_mem.sv
// MEM stage: req/ack data-memory access with stall and timeout.
// Results land in the MEM/WB register feeding write-back.
module pipe_mem
    import pipe_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              MEMwreg,
    input  logic              MEMm2reg,
    input  logic              MEMwmem,
    input  logic [REGN_W-1:0] MEMwn,
    input  logic [WORD_W-1:0] MEMaluResult,
    input  logic [WORD_W-1:0] MEMdi,
    output logic              dreq,
    output logic              dwe,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dwdata,
    input  logic [WORD_W-1:0] drdata,
    input  logic              dack,
    output logic              stall,
    output logic              buserr,
    output logic              WBwreg,
    output logic              WBm2reg,
    output logic [REGN_W-1:0] WBwn,
    output logic [WORD_W-1:0] WBaluResult,
    output logic [WORD_W-1:0] WBmemOut
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             memop;
    logic             busy;
    logic             done;
    logic             abort;
    logic             is_load;

    assign memop   = MEMm2reg | MEMwmem;
    assign is_load = MEMm2reg & ~MEMwmem;
    assign busy    = (state == ST_BUSY);

    assign dreq   = (~busy & memop) | busy;
    assign dwe    = MEMwmem;
    assign daddr  = MEMaluResult;
    assign dwdata = MEMdi;

    assign done  = dreq & dack;
    assign abort = busy & ~dack & (cnt == CNT_W'(TIMEOUT - 1));
    assign stall = dreq & ~dack & ~abort;

    // Access FSM with timeout counter and sticky bus-error flag.
    always_ff @(posedge clk) begin
        if (clrn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            buserr <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (memop & ~dack) begin
                        state <= ST_BUSY;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (dack) begin
                        state <= ST_IDLE;
                    end else if (abort) begin
                        state  <= ST_IDLE;
                        buserr <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb (
        .clk        (clk),
        .clr        (clrn),
        .bubble     (stall | abort),
        .en         (~memop | done),
        .cap        (done & is_load),
        .next_wreg  (MEMwreg),
        .next_m2reg (MEMm2reg),
        .next_wn    (MEMwn),
        .next_alu   (MEMaluResult),
        .next_mem   (drdata),
        .wb_wreg    (WBwreg),
        .wb_m2reg   (WBm2reg),
        .wb_wn      (WBwn),
        .wb_alu     (WBaluResult),
        .wb_mem     (WBmemOut)
    );

endmodule

// File: tb/tb_pipe_mem.sv
// Self-checking bench for pipe_mem.
// Expected MEM/WB contents are queued at issue and compared at retire.
module tb_pipe_mem;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [4:0]  wn;
        logic [31:0] alu;
        logic [31:0] mo;
    } wb_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic        MEMwreg, MEMm2reg, MEMwmem;
    logic [4:0]  MEMwn;
    logic [31:0] MEMaluResult, MEMdi;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata, drdata;
    logic        dack;
    logic        stall, buserr;
    logic        WBwreg, WBm2reg;
    logic [4:0]  WBwn;
    logic [31:0] WBaluResult, WBmemOut;

    int  n_checks = 0;
    int  n_pass   = 0;
    wb_t sb[$];
    wb_t m;
    wb_t got;
    wb_t exp_v;

    always #5 clk = ~clk;

    pipe_mem #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .MEMwreg      (MEMwreg),
        .MEMm2reg     (MEMm2reg),
        .MEMwmem      (MEMwmem),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .MEMdi        (MEMdi),
        .dreq         (dreq),
        .dwe          (dwe),
        .daddr        (daddr),
        .dwdata       (dwdata),
        .drdata       (drdata),
        .dack         (dack),
        .stall        (stall),
        .buserr       (buserr),
        .WBwreg       (WBwreg),
        .WBm2reg      (WBm2reg),
        .WBwn         (WBwn),
        .WBaluResult  (WBaluResult),
        .WBmemOut     (WBmemOut)
    );

    task automatic drive(input logic wr, input logic ld, input logic st,
                         input logic [4:0] wn, input logic [31:0] a,
                         input logic [31:0] di);
        MEMwreg = wr; MEMm2reg = ld; MEMwmem = st;
        MEMwn = wn; MEMaluResult = a; MEMdi = di;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b1; dack = 1'b0; drdata = '0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        step();
        step();
        m = '0;
        sb.push_back(m);
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) $display("FAIL reset_wb: got %h want %h", got, exp_v);
        else n_pass++;
        clrn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dreq, stall, buserr} !== 3'b000)
            $display("FAIL reset_ctl: got %b want 000", {dreq, stall, buserr});
        else n_pass++;
        step();
    endtask

    task automatic test_alu();
        drive(1, 0, 0, 5'd5, 32'h1234, 32'h0);
        m = '{1'b1, 1'b0, 5'd5, 32'h1234, m.mo};
        sb.push_back(m);
        @(negedge clk);
        n_checks++;
        if ({stall, dreq} !== 2'b00)
            $display("FAIL alu_ctl: got %b want 00", {stall, dreq});
        else n_pass++;
        step();
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) $display("FAIL alu_wb: got %h want %h", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_zero_wait_load();
        drive(1, 1, 0, 5'd7, 32'h40, 32'h0);
        dack = 1'b1; drdata = 32'hDEADBEEF;
        m = '{1'b1, 1'b1, 5'd7, 32'h40, 32'hDEADBEEF};
        sb.push_back(m);
        @(negedge clk);
        n_checks++;
        if ({stall, dreq, dwe, daddr} !== {3'b010, 32'h40})
            $display("FAIL zw_ctl: got %b %h want 010 00000040",
                     {stall, dreq, dwe}, daddr);
        else n_pass++;
        step();
        dack = 1'b0; drdata = 32'h0;
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) $display("FAIL zw_wb: got %h want %h", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_store_wait3();
        drive(0, 0, 1, 5'd3, 32'h80, 32'hA5A5A5A5);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dack = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({dreq, dwe, stall, daddr, dwdata} !==
                {2'b11, (i < 3), 32'h80, 32'hA5A5A5A5})
                $display("FAIL st_bus%0d: got %b %h %h want %b 80 a5a5a5a5",
                         i, {dreq, dwe, stall}, daddr, dwdata,
                         {2'b11, (i < 3)});
            else n_pass++;
            if (i < 3) begin
                m.wreg = 1'b0; m.m2reg = 1'b0;
            end else begin
                m = '{1'b0, 1'b0, 5'd3, 32'h80, m.mo};
            end
            sb.push_back(m);
            step();
            got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
            exp_v = sb.pop_front();
            n_checks++;
            if (got !== exp_v)
                $display("FAIL st_wb%0d: got %h want %h", i, got, exp_v);
            else n_pass++;
        end
        dack = 1'b0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_timeout();
        drive(1, 1, 0, 5'd9, 32'h100, 32'h0);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            n_checks++;
            if ({dreq, stall, buserr} !== {1'b1, (i < 16), 1'b0})
                $display("FAIL to_cyc%0d: got %b want %b", i,
                         {dreq, stall, buserr}, {1'b1, (i < 16), 1'b0});
            else n_pass++;
            m.wreg = 1'b0; m.m2reg = 1'b0;
            step();
        end
        sb.push_back(m);
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v || buserr !== 1'b1)
            $display("FAIL to_abort: got %h err %b want %h err 1",
                     got, buserr, exp_v);
        else n_pass++;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        dack = 1'b1; drdata = 32'h12345678;
        m = '{1'b0, 1'b0, 5'd0, 32'h0, m.mo};
        sb.push_back(m);
        @(negedge clk);
        n_checks++;
        if ({dreq, stall} !== 2'b00)
            $display("FAIL unsol_ctl: got %b want 00", {dreq, stall});
        else n_pass++;
        step();
        dack = 1'b0; drdata = 32'h0;
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v || buserr !== 1'b1)
            $display("FAIL unsol_wb: got %h err %b want %h err 1",
                     got, buserr, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 5'd4, 32'h200, 32'h0);
        step();
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1)
            $display("FAIL rm_busy: got %b want 1", stall);
        else n_pass++;
        clrn = 1'b1;
        m = '0;
        sb.push_back(m);
        step();
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v || buserr !== 1'b0)
            $display("FAIL rm_clear: got %h err %b want %h err 0",
                     got, buserr, exp_v);
        else n_pass++;
        clrn = 1'b0;
        drive(1, 0, 0, 5'd6, 32'hBEEF, 32'h0);
        m = '{1'b1, 1'b0, 5'd6, 32'hBEEF, 32'h0};
        sb.push_back(m);
        @(negedge clk);
        n_checks++;
        if ({dreq, stall} !== 2'b00)
            $display("FAIL rm_idle: got %b want 00", {dreq, stall});
        else n_pass++;
        step();
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) $display("FAIL rm_alu: got %h want %h", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 5'd10, 32'h300, 32'h0);
        m.wreg = 1'b0; m.m2reg = 1'b0;
        sb.push_back(m);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) $display("FAIL b2b_stall: got %b want 1", stall);
        else n_pass++;
        step();
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) $display("FAIL b2b_bubble: got %h want %h", got, exp_v);
        else n_pass++;
        dack = 1'b1; drdata = 32'hCAFEF00D;
        m = '{1'b1, 1'b1, 5'd10, 32'h300, 32'hCAFEF00D};
        sb.push_back(m);
        @(negedge clk);
        n_checks++;
        if ({dreq, stall} !== 2'b10)
            $display("FAIL b2b_ack: got %b want 10", {dreq, stall});
        else n_pass++;
        step();
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) $display("FAIL b2b_load: got %h want %h", got, exp_v);
        else n_pass++;
        dack = 1'b0; drdata = 32'h0;
        drive(1, 0, 0, 5'd11, 32'h55, 32'h0);
        m = '{1'b1, 1'b0, 5'd11, 32'h55, 32'hCAFEF00D};
        sb.push_back(m);
        step();
        got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) $display("FAIL b2b_alu: got %h want %h", got, exp_v);
        else n_pass++;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_zero_wait_load();
        test_store_wait3();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
